// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: checks heartbeat half-periods against a tolerance window; reports alive or a sticky fault with cause code.
module heartbeat_monitor #(
    parameter int EXP_HALF_COUNTS = 50_000_000,
    parameter int TOL_COUNTS      = 1_000_000,
    parameter int GOOD_REQ        = 4,
    localparam int LO = EXP_HALF_COUNTS - TOL_COUNTS,
    localparam int HI = EXP_HALF_COUNTS + TOL_COUNTS,
    localparam int W  = $clog2(HI + 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         hb_in,
    output logic         alive,
    output logic         fault,
    output logic [1:0]   fault_code,
    output logic [W-1:0] last_interval
);
    localparam int GW = $clog2(GOOD_REQ + 1);
    typedef enum logic [2:0] {IDLE, SYNC, CHECK, ALIVE, FAULT} state_t;
    state_t state, state_n;
    logic s1, s2, s3, hb_edge, timeout, is_short, is_long;
    logic [W-1:0] cnt, meas, last_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [1:0] code_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2, s3} <= '0;
        else {s1, s2, s3} <= {hb_in, s1, s2};
    assign hb_edge  = s2 ^ s3;
    assign meas     = cnt + W'(1);
    assign is_short = meas < W'(LO);
    assign is_long  = meas > W'(HI);
    assign timeout  = cnt == W'(HI) && !hb_edge;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            good_cnt      <= '0;
            last_interval <= '0;
            fault_code    <= '0;
            alive         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= (state == IDLE || hb_edge) ? '0 : (cnt == W'(HI + 1)) ? cnt : cnt + W'(1);
            good_cnt      <= good_n;
            last_interval <= last_n;
            fault_code    <= code_n;
            alive         <= state_n == ALIVE;
            fault         <= state_n == FAULT;
        end
    always_comb begin
        state_n = state;
        if (!enable) state_n = IDLE;
        else case (state)
            IDLE:         state_n = SYNC;
            SYNC:         state_n = hb_edge ? CHECK : timeout ? FAULT : SYNC;
            CHECK, ALIVE: state_n = hb_edge ? ((is_short || is_long) ? FAULT :
                                    (state == ALIVE || good_cnt + GW'(1) == GW'(GOOD_REQ)) ? ALIVE : CHECK) :
                                    timeout ? FAULT : state;
            FAULT:        state_n = FAULT;
            default:      state_n = IDLE;
        endcase
    end
    // fault_code only ever changes on entry to FAULT, so it freezes there and stays 00 elsewhere
    always_comb begin
        good_n = good_cnt;
        last_n = last_interval;
        code_n = fault_code;
        if (!enable || state == IDLE) begin
            good_n = '0;
            last_n = '0;
            code_n = '0;
        end else if (state == SYNC) begin
            good_n = '0;
            code_n = timeout ? 2'b01 : 2'b00;
        end else if (state == CHECK || state == ALIVE) begin
            if (hb_edge) begin
                last_n = meas;
                code_n = is_short ? 2'b10 : is_long ? 2'b11 : 2'b00;
                good_n = (state == CHECK) ? good_cnt + GW'(1) : good_cnt;
            end else if (timeout) code_n = 2'b01;
        end
    end
endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb_heartbeat_monitor: directed and randomized bench for heartbeat_monitor against a timestamp-based reference model.
module tb_heartbeat_monitor;
    localparam int LO = 8, HI = 12, GREQ = 3;
    typedef enum int {M_IDLE, M_SYNC, M_CHECK, M_ALIVE, M_FAULT} mode_t;
    logic clk = 0, rst = 1, enable = 0, hb_in = 0;
    logic alive, fault;
    logic [1:0] fault_code;
    logic [3:0] last_interval;
    int total = 0, bad = 0;
    mode_t mode = M_IDLE;
    int cyc = 0, t_last = 0, goods = 0, e_last = 0, e_code = 0, since = 0;
    logic [2:0] smp = '0;
    int ph, nph, nn, guard;
    logic async_done, async_fault;

    heartbeat_monitor #(.EXP_HALF_COUNTS(10), .TOL_COUNTS(2), .GOOD_REQ(GREQ)) dut (
        .clk(clk), .rst(rst), .enable(enable), .hb_in(hb_in),
        .alive(alive), .fault(fault), .fault_code(fault_code), .last_interval(last_interval)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mode = M_IDLE; goods = 0; e_last = 0; e_code = 0; smp = '0; t_last = cyc;
    endtask

    task automatic fail_to(input int code);
        mode = M_FAULT; e_code = code;
    endtask

    // Intervals are differences of absolute cycle stamps of processed edges
    task automatic madvance();
        int gap;
        logic e;
        cyc++;
        e = smp[1] ^ smp[2];
        gap = cyc - t_last;
        if (!enable) begin
            mode = M_IDLE; goods = 0; e_last = 0; e_code = 0; t_last = cyc;
        end else if (mode == M_IDLE) begin
            mode = M_SYNC; t_last = cyc;
        end else if (mode == M_SYNC) begin
            if (e) begin mode = M_CHECK; goods = 0; t_last = cyc; end
            else if (gap == HI + 1) fail_to(1);
        end else if (mode != M_FAULT) begin
            if (e) begin
                e_last = gap; t_last = cyc;
                if (gap < LO) fail_to(2);
                else if (gap > HI) fail_to(3);
                else if (mode == M_CHECK) begin
                    goods++;
                    if (goods == GREQ) mode = M_ALIVE;
                end
            end else if (gap == HI + 1) fail_to(1);
        end
        smp = {smp[1:0], hb_in};
    endtask

    task automatic check(input string tag);
        cmp({tag, ".alive"}, alive, mode == M_ALIVE);
        cmp({tag, ".fault"}, fault, mode == M_FAULT);
        cmp({tag, ".code"}, fault_code, e_code);
        cmp({tag, ".last"}, last_interval, e_last);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) mreset(); else madvance();
        @(negedge clk);
        since++;
        check("model");
    endtask

    task automatic half(input int n);
        while (since < n) step();
        hb_in = ~hb_in;
        since = 0;
    endtask

    task automatic lock();
        repeat (5) half(int'($urandom_range(LO, HI)));
        repeat (3) step();
        cmp("lock.alive", alive, 1);
    endtask

    task automatic clear();
        enable = 0;
        step();
        cmp("clr.fault", fault, 0);
        cmp("clr.code", fault_code, 0);
        cmp("clr.last", last_interval, 0);
        enable = 1;
    endtask

    initial begin
        mreset();
        repeat (2) step();
        cmp("rst.alive", alive, 0);
        cmp("rst.fault", fault, 0);
        cmp("rst.code", fault_code, 0);
        cmp("rst.last", last_interval, 0);
        rst = 0;
        step();
        // lock at nominal period
        enable = 1;
        repeat (4) half(10);
        repeat (2) step();
        cmp("lock1.early", alive, 0);
        step();
        cmp("lock1.alive", alive, 1);
        cmp("lock1.last", last_interval, 10);
        // window bounds
        half(8);
        repeat (3) step();
        cmp("win.last8", last_interval, 8);
        half(12);
        repeat (3) step();
        cmp("win.last12", last_interval, 12);
        cmp("win.alive", alive, 1);
        half(7);
        repeat (3) step();
        cmp("short.fault", fault, 1);
        cmp("short.code", fault_code, 2);
        cmp("short.last", last_interval, 7);
        clear();
        lock();
        half(13);
        repeat (3) step();
        cmp("long.code", fault_code, 3);
        cmp("long.last", last_interval, 13);
        // timeout from ALIVE and from SYNC
        clear();
        lock();
        repeat (12) step();
        cmp("to.pre_fault", fault, 0);
        cmp("to.pre_alive", alive, 1);
        step();
        cmp("to.fault", fault, 1);
        cmp("to.alive", alive, 0);
        cmp("to.code", fault_code, 1);
        clear();
        repeat (13) step();
        cmp("sync_to.pre", fault, 0);
        step();
        cmp("sync_to.fault", fault, 1);
        cmp("sync_to.code", fault_code, 1);
        // sticky fault, then clear and relock
        repeat (4) half(10);
        repeat (3) step();
        cmp("sticky.fault", fault, 1);
        cmp("sticky.code", fault_code, 1);
        clear();
        repeat (4) half(10);
        repeat (2) step();
        cmp("relock.early", alive, 0);
        step();
        cmp("relock.alive", alive, 1);
        // enable drop coincident with a short edge
        half(5);
        repeat (2) step();
        enable = 0;
        step();
        cmp("simul.fault", fault, 0);
        cmp("simul.alive", alive, 0);
        enable = 1;
        lock();
        // asynchronous reset mid-ALIVE
        #2 rst = 1;
        hb_in = 0;
        #1;
        cmp("arst.alive", alive, 0);
        cmp("arst.fault", fault, 0);
        cmp("arst.code", fault_code, 0);
        cmp("arst.last", last_interval, 0);
        mreset();
        step();
        rst = 0;
        step();
        // jittered heartbeat from an unrelated timebase
        repeat (5) half(int'($urandom_range(LO, HI)));
        async_done = 0;
        async_fault = 0;
        fork
            begin
                ph = 0;
                repeat (30) begin
                    nph = int'($urandom_range(0, 6)) - 3;
                    nn = int'($urandom_range(9, 11));
                    #(10 * nn + nph - ph) hb_in = ~hb_in;
                    ph = nph;
                end
                async_done = 1;
            end
            begin
                guard = 0;
                while (!async_done && guard < 1000) begin
                    step();
                    guard++;
                    if (fault !== 1'b0) async_fault = 1;
                end
            end
        join
        cmp("async.done", async_done, 1);
        repeat (3) step();
        cmp("async.alive", alive, 1);
        cmp("async.nofault", async_fault, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
